tile_stream_sequencer: RTL and testbench
========================================

TILE_STREAM_SEQUENCER -- requirements
Module: tile_stream_sequencer

Interface
REQ-001 Parameter BIT_LENGTH, default 4, SHALL set the pixel width in bits.
REQ-002 Parameter LANES, default 5, SHALL set the number of pixels delivered per beat.
REQ-003 Parameter TILE_W, default 20, SHALL set the tile width in pixels.
REQ-004 Parameter TILE_H, default 20, SHALL set the tile height in pixels; TILE_W*TILE_H SHALL be a multiple of LANES.
REQ-005 Parameter TIMEOUT, default 1024, SHALL set the drain watchdog limit in cycles (used only with REQ-031).
REQ-006 clk  input  1  single clock; all logic on posedge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  upstream beat valid.
REQ-009 in_data  input  LANES*BIT_LENGTH  upstream beat, lane 0 in LSBs.
REQ-010 in_ready  output  1  sequencer accepts a beat.
REQ-011 core_reset  output  1  one-cycle reset pulse to the edge core.
REQ-012 pixel_out  output  LANES*BIT_LENGTH  registered beat to the core, lane k at bits [k*BIT_LENGTH +: BIT_LENGTH].
REQ-013 load_end  output  1  last beat of the tile is present or has been sent.
REQ-014 readable  input  1  core edge bit valid this cycle.
REQ-015 edge_in  input  1  core edge bit.
REQ-016 edge_valid, edge_out  output  1 each  forwarded edge stream.
REQ-017 tile_done  output  1  one-cycle pulse after the last edge bit of a tile.
REQ-018 tile_count  output  16  number of completed tiles, wrapping at 65535 -> 0.

Function
REQ-019 BEATS = TILE_W*TILE_H/LANES and OUTS = (TILE_W-2)*(TILE_H-2) SHALL be derived constants (80 and 324 at defaults).
REQ-020 The FSM SHALL have three states: CRST, LOAD and DRAIN.
  - CRST: core_reset=1 for exactly one cycle, then go to LOAD.
  - LOAD: in_ready=1; each in_valid&&in_ready beat is registered onto pixel_out on the next cycle and beat_cnt increments.
  - DRAIN: in_ready=0; pixel_out holds its value.
REQ-021 The accepted beat with beat_cnt==BEATS-1 SHALL appear on pixel_out with load_end=1 in the same cycle, and the FSM SHALL move to DRAIN.
REQ-022 load_end SHALL stay 1 throughout DRAIN and SHALL clear on entry to CRST.
REQ-023 In every state, edge_valid=readable and edge_out=edge_in, registered with 1-cycle latency; out_cnt SHALL count accepted bits.
REQ-024 When out_cnt reaches OUTS, the sequencer SHALL:
  - pulse tile_done the following cycle;
  - increment tile_count;
  - clear both counters;
  - enter CRST.
REQ-025 readable asserted while not in DRAIN SHALL still be forwarded and counted (the core may lead load_end).
REQ-026 readable arriving in the cycle out_cnt reaches OUTS SHALL be counted in the finishing tile; further bits before CRST exits SHALL be dropped and not forwarded.
REQ-027 A gap in in_valid SHALL leave pixel_out and beat_cnt unchanged; there is no bubble insertion.

Reset
REQ-028 On reset the sequencer SHALL enter CRST with the following values:
  - in_ready=0, pixel_out=0, load_end=0, edge_valid=0, edge_out=0, tile_done=0, tile_count=0;
  - beat_cnt=0, out_cnt=0.
REQ-029 Reset asserted mid-tile SHALL abandon the tile with no tile_done and SHALL re-issue core_reset on the first cycle after reset deasserts.

Configuration
REQ-030 The macro TSS_WATCHDOG_EN SHALL enable the drain watchdog.
REQ-031 With TSS_WATCHDOG_EN defined:
  - a counter runs in DRAIN and is cleared on every readable;
  - at TIMEOUT cycles the sequencer pulses output timeout_err (1 bit, reset 0) for one cycle, discards the tile without tile_done or tile_count change, and enters CRST.
REQ-032 With TSS_WATCHDOG_EN undefined, timeout_err and its counter SHALL NOT exist, and DRAIN SHALL wait indefinitely.

Structure
REQ-033 A shared package tss_pkg SHALL hold the state enum (CRST, LOAD, DRAIN) and the BEATS/OUTS computation functions.
REQ-034 Sub-module tss_beat_reg SHALL implement the LANES*BIT_LENGTH beat register with load enable; all other logic SHALL be in the top level.

Verification
REQ-035 Reset, then hold in_valid=1 for 80 beats at defaults: core_reset is seen in the cycle after reset, load_end=1 together with beat 80, and in_ready=0 from then on.
REQ-036 At defaults, feed 324 readable pulses with the pattern edge_in=j%2: edge_out matches with 1-cycle latency, tile_done pulses once, tile_count=1, and core_reset follows.
REQ-037 Run three back-to-back tiles with in_valid toggling 1,0,1,0: beat_cnt stalls on each gap, each tile takes 160 input cycles, and tile_count ends at 3.
REQ-038 Assert reset at beat 40: no tile_done, then core_reset, and the next tile requires a full 80 beats.
REQ-039 Build with LANES=4, TILE_W=TILE_H=10: load_end arrives on beat 25 and tile_done after 64 edge bits.
REQ-040 With TSS_WATCHDOG_EN defined and TIMEOUT=16, stop readable after 100 bits: timeout_err pulses 16 cycles later, tile_count stays unchanged, and CRST follows.

Source files
------------

// File: rtl/tss_pkg.sv
// -----------------------------------------------------------------------------
// tss_pkg -- shared types and helpers for the tile stream sequencer.
//
// Contents:
//   tss_state_t  : sequencer FSM state (CRST, LOAD, DRAIN)
//   calc_beats() : number of input beats that make up one tile
//   calc_outs()  : number of edge bits the core produces per tile (the core
//                  drops a one-pixel border, hence the -2 on each axis)
// -----------------------------------------------------------------------------
package tss_pkg;

  typedef enum logic [1:0] {
    CRST  = 2'd0,  // pulse core_reset for one cycle
    LOAD  = 2'd1,  // accept tile beats from upstream
    DRAIN = 2'd2   // all beats sent, wait for the core to finish
  } tss_state_t;

  function automatic int calc_beats(input int tile_w, input int tile_h, input int lanes);
    return (tile_w * tile_h) / lanes;
  endfunction

  function automatic int calc_outs(input int tile_w, input int tile_h);
    return (tile_w - 2) * (tile_h - 2);
  endfunction

endpackage : tss_pkg

// File: rtl/tss_beat_reg.sv
// -----------------------------------------------------------------------------
// tss_beat_reg -- WIDTH-bit beat register with load enable.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, clears q
//   load   : capture d on the next edge
//   d      : beat to capture
//   q      : registered beat, held while load is low
// -----------------------------------------------------------------------------
module tss_beat_reg #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // the datapath register is reset as well because the core may observe it
  // right after reset and must see a defined zero beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : tss_beat_reg

// File: rtl/tile_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tile_stream_sequencer -- feeds one tile of pixels to an edge core and
// forwards the core's edge bits back out, counting completed tiles.
//
// Flow per tile: CRST (one-cycle core_reset) -> LOAD (accept BEATS beats)
// -> DRAIN (wait for the remaining edge bits) -> CRST.  Edge bits are
// forwarded and counted in every state; a tile ends on the cycle the
// OUTS-th bit is accepted, so tile_done rises on the following cycle,
// together with that final forwarded bit.
//
// Ports:
//   clk, reset           : clock; synchronous active-high reset
//   in_valid, in_data    : upstream beat, lane 0 in the LSBs
//   in_ready             : high in LOAD only
//   core_reset           : one-cycle reset pulse to the edge core (CRST)
//   pixel_out            : registered beat to the core
//   load_end             : last beat of the tile is on pixel_out / was sent
//   readable, edge_in    : edge bit from the core
//   edge_valid, edge_out : forwarded edge bit, one cycle later
//   tile_done            : one-cycle pulse when a tile's edge bits are done
//   tile_count           : completed tiles, wraps at 16 bits
//   timeout_err          : drain watchdog pulse (TSS_WATCHDOG_EN only)
//
// Build option: define TSS_WATCHDOG_EN to add a DRAIN watchdog that
// abandons the tile after TIMEOUT cycles without a readable bit.
// -----------------------------------------------------------------------------
module tile_stream_sequencer
  import tss_pkg::*;
#(
  parameter int BIT_LENGTH = 4,
  parameter int LANES      = 5,
  parameter int TILE_W     = 20,
  parameter int TILE_H     = 20,
  parameter int TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [LANES*BIT_LENGTH-1:0] in_data,
  output logic                        in_ready,
  output logic                        core_reset,
  output logic [LANES*BIT_LENGTH-1:0] pixel_out,
  output logic                        load_end,
  input  logic                        readable,
  input  logic                        edge_in,
  output logic                        edge_valid,
  output logic                        edge_out,
  output logic                        tile_done,
`ifdef TSS_WATCHDOG_EN
  output logic                        timeout_err,
`endif
  output logic [15:0]                 tile_count
);

  localparam int BEATS = calc_beats(TILE_W, TILE_H, LANES);
  localparam int OUTS  = calc_outs(TILE_W, TILE_H);
  localparam int BCW   = $clog2(BEATS + 1);
  localparam int OCW   = $clog2(OUTS + 1);

  tss_state_t     state_q, state_d;
  logic [BCW-1:0] beat_cnt;
  logic [OCW-1:0] out_cnt;
  logic           drop_q;       // high only in the CRST cycle that ends a tile
  logic           beat_accept;
  logic           last_beat;
  logic           edge_accept;
  logic           done_hit;
  logic           timeout_hit;
  logic           tile_end;

  assign beat_accept = in_valid && in_ready;
  assign last_beat   = beat_accept && (beat_cnt == BCW'(BEATS - 1));
  // Bits arriving between the end of a tile and the exit of its CRST cycle
  // belong to no tile and are dropped; after a plain reset they still count.
  assign edge_accept = readable && !drop_q;
  assign done_hit    = edge_accept && (out_cnt == OCW'(OUTS - 1));
  assign tile_end    = done_hit || timeout_hit;

`ifdef TSS_WATCHDOG_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0] wd_cnt;

  assign timeout_hit = (state_q == DRAIN) && !readable && (wd_cnt == WCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state_q != DRAIN || readable || timeout_hit) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    core_reset = 1'b0;
    case (state_q)
      CRST: begin
        core_reset = 1'b1;
        state_d    = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: state_d = CRST;
    endcase
    // Finishing or abandoning a tile wins over any load progress.
    if (tile_end) state_d = CRST;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CRST;
      beat_cnt   <= '0;
      out_cnt    <= '0;
      load_end   <= 1'b0;
      edge_valid <= 1'b0;
      edge_out   <= 1'b0;
      tile_done  <= 1'b0;
      tile_count <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_valid <= edge_accept;
      edge_out   <= edge_in && !drop_q;
      tile_done  <= done_hit;
      drop_q     <= tile_end;
      if (tile_end) begin
        beat_cnt <= '0;
        out_cnt  <= '0;
        load_end <= 1'b0;
      end else begin
        if (beat_accept) beat_cnt <= beat_cnt + 1'b1;
        if (last_beat)   load_end <= 1'b1;
        if (edge_accept) out_cnt  <= out_cnt + 1'b1;
      end
      if (done_hit) tile_count <= tile_count + 16'd1;
    end
  end

  tss_beat_reg #(
    .WIDTH (LANES * BIT_LENGTH)
  ) u_beat_reg (
    .clk   (clk),
    .reset (reset),
    .load  (beat_accept),
    .d     (in_data),
    .q     (pixel_out)
  );

endmodule : tile_stream_sequencer

// File: tb/tb_tile_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tile_stream_sequencer -- directed bench for tile_stream_sequencer.
// One instance at default geometry (20x20, 5 lanes, 80 beats, 324 edge bits)
// and one at 10x10 with 4 lanes (25 beats, 64 edge bits).  Inputs change
// 1 ns after the rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_tile_stream_sequencer;

  localparam int BEATS   = 80;
  localparam int OUTS    = 324;
  localparam int DW      = 20;
  localparam int S_BEATS = 25;
  localparam int S_OUTS  = 64;
  localparam int S_DW    = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          core_reset;
  logic [DW-1:0] pixel_out;
  logic          load_end;
  logic          readable;
  logic          edge_in;
  logic          edge_valid;
  logic          edge_out;
  logic          tile_done;
  logic [15:0]   tile_count;
`ifdef TSS_WATCHDOG_EN
  logic          timeout_err;
  logic          s_timeout_err;
`endif

  logic            s_in_valid;
  logic [S_DW-1:0] s_in_data;
  logic            s_in_ready;
  logic            s_core_reset;
  logic [S_DW-1:0] s_pixel_out;
  logic            s_load_end;
  logic            s_readable;
  logic            s_edge_in;
  logic            s_edge_valid;
  logic            s_edge_out;
  logic            s_tile_done;
  logic [15:0]     s_tile_count;

  int            tests_run = 0;
  int            errors    = 0;
  int            exp_tiles = 0;
  logic [DW-1:0] exp_pix   = '0;

  tile_stream_sequencer #(
    .BIT_LENGTH (4),
    .LANES      (5),
    .TILE_W     (20),
    .TILE_H     (20),
    .TIMEOUT    (16)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .core_reset  (core_reset),
    .pixel_out   (pixel_out),
    .load_end    (load_end),
    .readable    (readable),
    .edge_in     (edge_in),
    .edge_valid  (edge_valid),
    .edge_out    (edge_out),
    .tile_done   (tile_done),
`ifdef TSS_WATCHDOG_EN
    .timeout_err (timeout_err),
`endif
    .tile_count  (tile_count)
  );

  tile_stream_sequencer #(
    .BIT_LENGTH (4),
    .LANES      (4),
    .TILE_W     (10),
    .TILE_H     (10),
    .TIMEOUT    (16)
  ) u_small (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (s_in_valid),
    .in_data     (s_in_data),
    .in_ready    (s_in_ready),
    .core_reset  (s_core_reset),
    .pixel_out   (s_pixel_out),
    .load_end    (s_load_end),
    .readable    (s_readable),
    .edge_in     (s_edge_in),
    .edge_valid  (s_edge_valid),
    .edge_out    (s_edge_out),
    .tile_done   (s_tile_done),
`ifdef TSS_WATCHDOG_EN
    .timeout_err (s_timeout_err),
`endif
    .tile_count  (s_tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] beat_word(input int seed, input int b);
    logic [31:0] w;
    w = (seed * 32'd1000) + (b * 32'd37) + 32'd5;
    w = w ^ (32'(b) << 11);
    return w[DW-1:0];
  endfunction

  function automatic logic edge_bit(input int pat, input int j);
    case (pat)
      0:       return logic'(j % 2);
      1:       return (j % 3) == 0;
      default: return logic'((j >> 2) & 1);
    endcase
  endfunction

  task automatic do_reset();
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    readable   = 1'b0;
    edge_in    = 1'b0;
    s_in_valid = 1'b0;
    s_in_data  = '0;
    s_readable = 1'b0;
    s_edge_in  = 1'b0;
    step();
    step();
    check("rst_in_ready",   in_ready,   0);
    check("rst_pixel_out",  pixel_out,  0);
    check("rst_load_end",   load_end,   0);
    check("rst_edge_valid", edge_valid, 0);
    check("rst_edge_out",   edge_out,   0);
    check("rst_tile_done",  tile_done,  0);
    check("rst_tile_count", tile_count, 0);
`ifdef TSS_WATCHDOG_EN
    check("rst_timeout_err", timeout_err, 0);
`endif
    reset     = 1'b0;
    exp_tiles = 0;
    exp_pix   = '0;
    check("core_reset_after_rst", core_reset, 1);
    step();
    check("core_reset_one_cycle", core_reset, 0);
    check("in_ready_in_load",     in_ready,   1);
  endtask

  // Load one tile; with gaps, in_valid alternates 1,0 and a garbage word is
  // presented on the idle cycles so any wrongly accepted gap shows up.
  task automatic load_tile(input bit gaps, input int seed);
    int   beat;
    logic v;
    beat = 0;
    for (int c = 0; c < (gaps ? 2 * BEATS : BEATS); c++) begin
      v        = !gaps || (c % 2 == 0);
      in_valid = v;
      in_data  = v ? beat_word(seed, beat) : ~beat_word(seed, beat);
      check("in_ready", in_ready, 32'(beat < BEATS));
      step();
      if (v) begin
        exp_pix = beat_word(seed, beat);
        beat++;
      end
      check("pixel_out", pixel_out, exp_pix);
      check("load_end",  load_end,  32'(beat == BEATS));
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Feed exactly one tile's edge bits, then one more bit during the CRST
  // cycle, which must be dropped.
  task automatic drain_tile(input int pat);
    logic b;
    for (int j = 0; j < OUTS; j++) begin
      b        = edge_bit(pat, j);
      readable = 1'b1;
      edge_in  = b;
      step();
      check("edge_valid", edge_valid, 1);
      check("edge_out",   edge_out,   b);
      check("tile_done",  tile_done,  32'(j == OUTS - 1));
    end
    exp_tiles++;
    check("tile_count",     tile_count, exp_tiles);
    check("core_reset_end", core_reset, 1);
    check("load_end_clr",   load_end,   0);
    readable = 1'b1;
    edge_in  = 1'b1;
    step();
    check("edge_drop_crst",  edge_valid, 0);
    check("tile_done_pulse", tile_done,  0);
    check("crst_one_cycle",  core_reset, 0);
    check("next_in_ready",   in_ready,   1);
    readable = 1'b0;
    edge_in  = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single tile at full rate, then DRAIN must hold pixel_out.
    load_tile(1'b0, 1);
    in_valid = 1'b1;
    in_data  = 20'hABCDE;
    step();
    check("drain_in_ready",  in_ready,  0);
    check("drain_pix_hold",  pixel_out, exp_pix);
    check("drain_load_end",  load_end,  1);
    in_valid = 1'b0;
    drain_tile(0);

    // Reset in the middle of the load.
    for (int b = 0; b < 40; b++) begin
      in_valid = 1'b1;
      in_data  = beat_word(2, b);
      step();
      check("mid_pixel_out", pixel_out, beat_word(2, b));
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    check("mid_rst_tile_done",  tile_done,  0);
    check("mid_rst_tile_count", tile_count, 0);
    check("mid_rst_pixel_out",  pixel_out,  0);
    check("mid_rst_load_end",   load_end,   0);
    reset     = 1'b0;
    exp_tiles = 0;
    exp_pix   = '0;
    check("mid_rst_core_reset", core_reset, 1);
    step();
    load_tile(1'b0, 3);
    drain_tile(1);

    // Three back-to-back tiles with in_valid toggling.
    do_reset();
    for (int t = 0; t < 3; t++) begin
      load_tile(1'b1, 10 + t);
      drain_tile(t);
    end
    check("three_tiles", tile_count, 3);

    // Small geometry: 25 beats of 4 lanes, 64 edge bits.
    for (int b = 0; b < S_BEATS; b++) begin
      s_in_valid = 1'b1;
      s_in_data  = S_DW'(b * 13 + 1);
      step();
      check("s_pixel_out", s_pixel_out, S_DW'(b * 13 + 1));
      check("s_load_end",  s_load_end,  32'(b == S_BEATS - 1));
    end
    s_in_valid = 1'b0;
    check("s_in_ready_drain", s_in_ready, 0);
    for (int j = 0; j < S_OUTS; j++) begin
      s_readable = 1'b1;
      s_edge_in  = edge_bit(2, j);
      step();
      check("s_edge_out",  s_edge_out,  edge_bit(2, j));
      check("s_tile_done", s_tile_done, 32'(j == S_OUTS - 1));
    end
    s_readable = 1'b0;
    check("s_tile_count", s_tile_count, 1);
    check("s_core_reset", s_core_reset, 1);

`ifdef TSS_WATCHDOG_EN
    // Watchdog: 100 bits, then silence; pulse expected 16 cycles later.
    load_tile(1'b0, 7);
    for (int j = 0; j < 100; j++) begin
      readable = 1'b1;
      edge_in  = edge_bit(0, j);
      step();
    end
    readable = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      check("wd_quiet", timeout_err, 0);
    end
    step();
    check("wd_pulse",      timeout_err, 1);
    check("wd_core_reset", core_reset,  1);
    check("wd_tile_count", tile_count,  exp_tiles);
    check("wd_no_done",    tile_done,   0);
    check("wd_load_end",   load_end,    0);
    step();
    check("wd_one_cycle",  timeout_err, 0);
    check("wd_in_ready",   in_ready,    1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule : tb_tile_stream_sequencer
